// File: rtl/bit_normalizer_seq_if.sv
// Start/done handshake bundle for the sequential bit normaliser.
interface bit_normalizer_seq_if #(
   parameter int WIDTH = 8,
   parameter int SW    = 3
) ();
   logic             start;
   logic [WIDTH-1:0] in;
   logic             dir;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic [SW-1:0]    shamt;
   logic             zero;

   modport master (output start, in, dir, input busy, done, out, shamt, zero);
   modport slave  (input start, in, dir, output busy, done, out, shamt, zero);
endinterface

// File: rtl/bit_normalizer_seq.sv
// Sequential normaliser: shifts a word one bit per clock until its leading set
// bit reaches the chosen edge, recovering the shift count for the barrel shifter.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | shifting toward target edge, one bit per clock
// DONE  | one-cycle result strobe; start here chains the next operation
module bit_normalizer_seq #(
   parameter int WIDTH = 8,
   parameter int SW    = 3
) (
   input  logic clk,
   input  logic rst_n,
   bit_normalizer_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             dir_q,   dir_d;
   logic [SW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] out_q,   out_d;
   logic [SW-1:0]    shamt_q, shamt_d;
   logic             zero_q,  zero_d;
   logic             target;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         dir_q   <= 1'b0;
         count_q <= '0;
         out_q   <= '0;
         shamt_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         count_q <= count_d;
         out_q   <= out_d;
         shamt_q <= shamt_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      dir_d   = dir_q;
      count_d = count_q;
      out_d   = out_q;
      shamt_d = shamt_q;
      zero_d  = zero_q;
      target  = dir_q ? data_q[0] : data_q[WIDTH-1];
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               data_d  = bus.in;
               dir_d   = bus.dir;
               count_d = '0;
               zero_d  = 1'b0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (data_q == '0) begin
               zero_d  = 1'b1;
               shamt_d = '0;
               out_d   = '0;
               state_d = DONE;
            end else if (target) begin
               out_d   = data_q;
               shamt_d = count_q;
               state_d = DONE;
            end else begin
               data_d = dir_q ? (data_q >> 1) : (data_q << 1);
               // A nonzero word reaches the edge by WIDTH-1 shifts; the guard only keeps count from wrapping.
               if (count_q != SW'(WIDTH - 1)) count_d = count_q + SW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy  = (state_q == SHIFT);
   assign bus.done  = (state_q == DONE);
   assign bus.out   = out_q;
   assign bus.shamt = shamt_q;
   assign bus.zero  = zero_q;

endmodule

// File: tb/tb_bit_normalizer_seq.sv
// Directed and exhaustive checks of bit_normalizer_seq against a barrel-shift model.
module tb_bit_normalizer_seq;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   lat, bcyc;

   bit_normalizer_seq_if #(.WIDTH(8), .SW(3)) bus ();

   bit_normalizer_seq #(.WIDTH(8), .SW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] barrel(input logic [7:0] d, input logic [2:0] sh, input logic dr);
      return dr ? (d >> sh) : (d << sh);
   endfunction

   // Issue one start at the next falling edge, then count edges until done.
   task automatic do_op(input logic [7:0] d, input logic dr, output int latency, output int busy_cycles);
      @(negedge clk);
      bus.start = 1'b1;
      bus.in    = d;
      bus.dir   = dr;
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      busy_cycles = bus.busy ? 1 : 0;
      latency     = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            latency = i;
            break;
         end
         if (bus.busy) busy_cycles++;
      end
      if (latency == 0) check("timeout", 32'd0, 32'd1);
      else check("busy_with_done", {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_res(input string tag, input logic [7:0] o, input logic [2:0] s, input logic z);
      check({tag, "_out"},   {24'd0, bus.out},   {24'd0, o});
      check({tag, "_shamt"}, {29'd0, bus.shamt}, {29'd0, s});
      check({tag, "_zero"},  {31'd0, bus.zero},  {31'd0, z});
   endtask

   initial begin
      logic [7:0] exp_out;
      logic [2:0] exp_sh;
      bus.start = 1'b0;
      bus.in    = 8'h00;
      bus.dir   = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("rst_busy",  {31'd0, bus.busy},  32'd0);
      check("rst_done",  {31'd0, bus.done},  32'd0);
      expect_res("rst", 8'h00, 3'd0, 1'b0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      do_op(8'h13, 1'b0, lat, bcyc);
      expect_res("left13", 8'h98, 3'd3, 1'b0);
      check("left13_lat", lat, 4);
      check("left13_busy", bcyc, 4);
      idle(2);
      check("idle_done_low", {31'd0, bus.done}, 32'd0);

      do_op(8'h80, 1'b0, lat, bcyc);
      expect_res("left80", 8'h80, 3'd0, 1'b0);
      check("left80_lat", lat, 1);
      idle(1);
      do_op(8'h01, 1'b0, lat, bcyc);
      expect_res("left01", 8'h80, 3'd7, 1'b0);
      check("left01_lat", lat, 8);
      idle(1);

      do_op(8'h28, 1'b1, lat, bcyc);
      expect_res("right28", 8'h05, 3'd3, 1'b0);
      idle(1);
      do_op(8'h80, 1'b1, lat, bcyc);
      expect_res("right80", 8'h01, 3'd7, 1'b0);
      idle(1);

      do_op(8'h00, 1'b0, lat, bcyc);
      expect_res("zero_l", 8'h00, 3'd0, 1'b1);
      check("zero_l_lat", lat, 1);
      idle(1);
      do_op(8'h00, 1'b1, lat, bcyc);
      expect_res("zero_r", 8'h00, 3'd0, 1'b1);
      check("zero_r_lat", lat, 1);
      idle(1);

      // Start held and input disturbed while shifting 0x13; zero must clear on acceptance.
      @(negedge clk);
      bus.start = 1'b1;
      bus.in    = 8'h13;
      bus.dir   = 1'b0;
      @(posedge clk);
      #1;
      check("accept_zero_clr", {31'd0, bus.zero}, 32'd0);
      check("accept_out_hold", {24'd0, bus.out}, 32'd0);
      bus.in  = 8'hFF;
      bus.dir = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      for (int i = 3; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      check("hold_lat", lat, 4);
      expect_res("hold", 8'h98, 3'd3, 1'b0);

      // Back-to-back: next start lands in the DONE cycle.
      check("b2b_in_done", {31'd0, bus.done}, 32'd1);
      do_op(8'h04, 1'b0, lat, bcyc);
      expect_res("b2b", 8'h80, 3'd5, 1'b0);
      check("b2b_lat", lat, 6);
      idle(1);

      // Reset in the middle of shifting 0x01.
      @(negedge clk);
      bus.start = 1'b1;
      bus.in    = 8'h01;
      bus.dir   = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      idle(3);
      check("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_busy",  {31'd0, bus.busy}, 32'd0);
      check("mid_done",  {31'd0, bus.done}, 32'd0);
      expect_res("mid", 8'h00, 3'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check("post_rst_done", {31'd0, bus.done}, 32'd0);
      do_op(8'h40, 1'b0, lat, bcyc);
      expect_res("post_rst", 8'h80, 3'd1, 1'b0);
      idle(1);

      for (int dr = 0; dr < 2; dr++) begin
         for (int v = 0; v < 256; v++) begin
            logic [7:0] vin;
            vin     = 8'(v);
            exp_sh  = 3'd0;
            exp_out = 8'h00;
            if (vin != 8'h00) begin
               for (int s = 0; s < 8; s++) begin
                  if ((dr == 0 && vin[7-s]) || (dr == 1 && vin[s])) begin
                     exp_sh = 3'(s);
                     break;
                  end
               end
               exp_out = barrel(vin, exp_sh, dr[0]);
            end
            do_op(vin, dr[0], lat, bcyc);
            check("ex_out",   {24'd0, bus.out},   {24'd0, exp_out});
            check("ex_shamt", {29'd0, bus.shamt}, {29'd0, exp_sh});
            check("ex_zero",  {31'd0, bus.zero},  {31'd0, (vin == 8'h00)});
            check("ex_lat",   lat, int'(exp_sh) + 1);
            if (vin != 8'h00) begin
               check("ex_edge", {31'd0, (dr == 0) ? bus.out[7] : bus.out[0]}, 32'd1);
               check("ex_inverse", {24'd0, barrel(bus.out, bus.shamt, ~dr[0])}, {24'd0, vin});
            end
            if (v[0]) idle(1);
         end
      end

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_normalizer_seq.md
Name: bit_normalizer_seq

Overview:
- Sequential inverse of the team's combinational 8-bit logical barrel shifter.
- Takes a data word and shifts it one bit per clock until the leading set bit reaches the edge.
  - dir=0: leading bit is the MSB (left-normalise).
  - dir=1: leading bit is the LSB (right-normalise).
- Reports the shift amount recovered.
- Used ahead of the barrel shifter to recover shamt (leading/trailing-zero count) and normalised data, via a start/done handshake.

Parameters:
- WIDTH, 8, data width in bits.
- SW, 3, shift-count width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk edge
- in  input  WIDTH  word to normalise; captured with start
- dir  input  1  0 = normalise toward MSB (shift left), 1 = toward LSB (shift right); captured with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result is valid
- out  output  WIDTH  normalised word
- shamt  output  SW  number of single-bit shifts applied
- zero  output  1  captured word was all zeros

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, out=0, shamt=0, zero=0.
  - Takes effect immediately, including mid-operation; any in-flight operation is discarded.
- State machine, all transitions on rising clk:
  - IDLE:
    - start=1 → load data register with in, latch dir, count=0, zero=0, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT (busy=1):
    - Target bit is data[WIDTH-1] if dir=0, data[0] if dir=1.
    - data==0 → zero=1, shamt=0, out=0, go to DONE.
    - Else target bit=1 → out=data, shamt=count, go to DONE.
    - Else shift data one bit toward the target edge, zero-filling the vacated bit; count=count+1; stay in SHIFT.
  - DONE (busy=0, done=1 for exactly one cycle):
    - start=1 → accepted as in IDLE, so back-to-back operations are supported.
    - Otherwise go to IDLE.
- Latency:
  - With k = shifts needed (0..WIDTH-1), done is high in the cycle after edge T0+k+1, where T0 is the edge that sampled start.
  - All-zero input: k=0, latency 1.
- count never exceeds WIDTH-1 for a nonzero word; no wrap is possible. The implementation must not let count wrap.
- start while in SHIFT is ignored, and in/dir changes are ignored.
- out, shamt and zero hold their last result until the next accepted start. On that start, zero clears; out and shamt update only on completion.
- Invariant (nonzero input):
  - dir=0: out = in << shamt, out[WIDTH-1]=1, and out >> shamt == in.
  - dir=1: out = in >> shamt, out[0]=1, and out << shamt == in.
- busy and done are never both high.

Test Plan:
- Left-normalise: in=0x13, dir=0 → shamt=3, out=0x98, zero=0; busy high for 4 cycles; done pulses 4 cycles after the start edge.
- Already normalised / extreme: in=0x80, dir=0 → shamt=0, out=0x80, latency 1. in=0x01, dir=0 → shamt=7, out=0x80, latency 8.
- Right-normalise: in=0x28, dir=1 → shamt=3, out=0x05. in=0x80, dir=1 → shamt=7, out=0x01.
- Zero word: in=0x00, either dir → zero=1, shamt=0, out=0x00, done after 1 cycle.
- Handshake:
  - start held and in changed to 0xFF during SHIFT of 0x13 → result still shamt=3, out=0x98.
  - start asserted in the DONE cycle with in=0x04, dir=0 → accepted; next result shamt=5, out=0x80.
- Reset mid-operation: rst_n low during SHIFT of 0x01 → busy, done, out, shamt and zero go to 0 immediately; after release, a new start with in=0x40, dir=0 → shamt=1, out=0x80.
- Exhaustive cross-check: all 256 values × 2 directions → check the invariant against the barrel shifter. Feed out with shamt into the barrel shifter in the opposite direction and confirm it returns in.
